mt9v032_sync_ctrl: RTL and testbench

//  Sequencer for WIDTH MT9V032 LVDS receive channels, all on clk_px.

---
 rtl/mt9v032_sync_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mt9v032_sync_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mt9v032_sync_ctrl.sv
// Training and alignment sequencer for WIDTH MT9V032 LVDS receive channels.
// Drives sensor/deserializer training, checks cross-channel frame skew, asserts rdy once locked.
module mt9v032_sync_ctrl #(
  parameter int WIDTH       = 1,
  parameter int TIMEOUT     = 65535,
  parameter int SKEW_MAX    = 4,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk_px,
  input  logic             rst_px,
  input  logic             en,
  input  logic [WIDTH-1:0] train_done,
  input  logic [WIDTH-1:0] frame_valid,
  output logic             sensor_train,
  output logic [WIDTH-1:0] train_start,
  output logic             rdy,
  output logic             err,
  output logic [7:0]       err_cnt,
  output logic [2:0]       state
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRAIN     = 3'd1,
    WAIT_DONE = 3'd2,
    RELEASE   = 3'd3,
    ALIGN     = 3'd4,
    RUN       = 3'd5
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] fv_q;
  logic [WIDTH-1:0] seen;
  logic [TW-1:0]    to_cnt;
  logic [4:0]       skew_cnt;
  logic [3:0]       frame_cnt;
  logic             run_track;

  logic [WIDTH-1:0] fv_rise;
  logic [WIDTH-1:0] seen_next;
  logic             all_done;
  logic             any_rise;
  logic             all_rise;
  logic             misalign;
  logic             aligned;
  logic             last_frame;
  logic             timeout;
  logic             fail;

  assign state = state_reg;

  always_comb begin
    fv_rise    = frame_valid & ~fv_q;
    seen_next  = seen | fv_rise;
    all_done   = &train_done;
    any_rise   = |fv_rise;
    all_rise   = &fv_rise;
    // skew_cnt + 1 is the number of cycles elapsed since the first rise of the frame
    misalign   = (|(fv_rise & seen)) || ((skew_cnt + 5'd1) > 5'(SKEW_MAX));
    aligned    = !misalign && (&seen_next);
    last_frame = (frame_cnt + 4'd1) == 4'(LOCK_FRAMES);
    timeout    = to_cnt == TW'(TIMEOUT - 1);
    fail       = 1'b0;
    case (state_reg)
      WAIT_DONE: fail = !all_done && timeout;
      RELEASE:   fail = !all_done;
      ALIGN:     fail = !all_done || misalign;
      RUN:       fail = !all_done || (run_track && misalign);
      default:   fail = 1'b0;
    endcase
  end

  always_ff @(posedge clk_px or posedge rst_px) begin
    if (rst_px) begin
      state_reg    <= IDLE;
      sensor_train <= 1'b1;
      train_start  <= '0;
      rdy          <= 1'b0;
      err          <= 1'b0;
      err_cnt      <= 8'd0;
      fv_q         <= '0;
      seen         <= '0;
      to_cnt       <= '0;
      skew_cnt     <= 5'd0;
      frame_cnt    <= 4'd0;
      run_track    <= 1'b0;
    end else begin
      fv_q        <= frame_valid;
      train_start <= '0;
      err         <= 1'b0;
      if (!en) begin
        state_reg    <= IDLE;
        sensor_train <= 1'b1;
        rdy          <= 1'b0;
        seen         <= '0;
        to_cnt       <= '0;
        skew_cnt     <= 5'd0;
        frame_cnt    <= 4'd0;
        run_track    <= 1'b0;
      end else if (fail) begin
        state_reg    <= TRAIN;
        train_start  <= '1;
        sensor_train <= 1'b1;
        rdy          <= 1'b0;
        err          <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        seen         <= '0;
        skew_cnt     <= 5'd0;
        frame_cnt    <= 4'd0;
        run_track    <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg   <= TRAIN;
            train_start <= '1;
          end
          TRAIN: begin
            state_reg <= WAIT_DONE;
            to_cnt    <= '0;
          end
          WAIT_DONE: begin
            if (all_done) begin
              state_reg    <= RELEASE;
              sensor_train <= 1'b0;
            end else begin
              to_cnt <= to_cnt + TW'(1);
            end
          end
          RELEASE: begin
            if (any_rise) begin
              // every channel rising together is a zero-skew frame, counted right away
              if (all_rise) begin
                if (last_frame) begin
                  state_reg <= RUN;
                  rdy       <= 1'b1;
                  frame_cnt <= 4'd0;
                end else begin
                  frame_cnt <= frame_cnt + 4'd1;
                end
              end else begin
                state_reg <= ALIGN;
                seen      <= fv_rise;
                skew_cnt  <= 5'd0;
              end
            end
          end
          ALIGN: begin
            if (aligned) begin
              seen <= '0;
              if (last_frame) begin
                state_reg <= RUN;
                rdy       <= 1'b1;
                frame_cnt <= 4'd0;
              end else begin
                state_reg <= RELEASE;
                frame_cnt <= frame_cnt + 4'd1;
              end
            end else begin
              seen     <= seen_next;
              skew_cnt <= skew_cnt + 5'd1;
            end
          end
          RUN: begin
            if (run_track) begin
              if (aligned) begin
                run_track <= 1'b0;
                seen      <= '0;
              end else begin
                seen     <= seen_next;
                skew_cnt <= skew_cnt + 5'd1;
              end
            end else if (any_rise && !all_rise) begin
              run_track <= 1'b1;
              seen      <= fv_rise;
              skew_cnt  <= 5'd0;
            end
          end
          default: begin
            state_reg    <= IDLE;
            sensor_train <= 1'b1;
            rdy          <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mt9v032_sync_ctrl.sv
// Directed bench for mt9v032_sync_ctrl: WIDTH=2, TIMEOUT=32, SKEW_MAX=4, LOCK_FRAMES=2.
module tb_mt9v032_sync_ctrl;
  localparam int WIDTH = 2;

  logic             clk_px = 1'b0;
  logic             rst_px = 1'b1;
  logic             en = 1'b0;
  logic [WIDTH-1:0] train_done = '0;
  logic [WIDTH-1:0] frame_valid = '0;
  logic             sensor_train;
  logic [WIDTH-1:0] train_start;
  logic             rdy;
  logic             err;
  logic [7:0]       err_cnt;
  logic [2:0]       state;

  int checks = 0;
  int errors = 0;

  mt9v032_sync_ctrl #(
    .WIDTH(WIDTH), .TIMEOUT(32), .SKEW_MAX(4), .LOCK_FRAMES(2)
  ) dut (
    .clk_px(clk_px), .rst_px(rst_px), .en(en), .train_done(train_done),
    .frame_valid(frame_valid), .sensor_train(sensor_train), .train_start(train_start),
    .rdy(rdy), .err(err), .err_cnt(err_cnt), .state(state)
  );

  always #5 clk_px = ~clk_px;

  task automatic tick();
    @(posedge clk_px);
    #1;
  endtask

  // channel 0 rises first, channel 1 follows skew cycles later; returns just after the last rise is clocked
  task automatic frame_rise(input int skew);
    frame_valid = (skew > 0) ? 2'b01 : 2'b11;
    repeat (skew) tick();
    frame_valid = 2'b11;
    tick();
  endtask

  task automatic frame_end();
    repeat (3) tick();
    frame_valid = 2'b00;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_px = 1'b1; en = 1'b0;
    repeat (2) tick();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (sensor_train !== 1'b1) begin errors++; $display("FAIL reset_sensor_train got %b exp 1", sensor_train); end
    checks++; if (train_start !== 2'b00) begin errors++; $display("FAIL reset_train_start got %b exp 00", train_start); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b exp 0", rdy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
    rst_px = 1'b0;
    tick();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL idle_hold got %0d exp 0", state); end
    $display("test_reset done");
  endtask

  task automatic test_lock();
    en = 1'b1;
    tick();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL lock_train_state got %0d exp 1", state); end
    checks++; if (train_start !== 2'b11) begin errors++; $display("FAIL lock_train_start got %b exp 11", train_start); end
    tick();
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL lock_wait_state got %0d exp 2", state); end
    checks++; if (train_start !== 2'b00) begin errors++; $display("FAIL lock_train_start_pulse got %b exp 00", train_start); end
    checks++; if (sensor_train !== 1'b1) begin errors++; $display("FAIL lock_sensor_train_wait got %b exp 1", sensor_train); end
    repeat (18) tick();
    train_done = 2'b11;
    tick();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL lock_release_state got %0d exp 3", state); end
    checks++; if (sensor_train !== 1'b0) begin errors++; $display("FAIL lock_sensor_train_rel got %b exp 0", sensor_train); end
    frame_rise(2);
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL lock_frame1_state got %0d exp 3", state); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL lock_frame1_rdy got %b exp 0", rdy); end
    frame_end();
    frame_rise(2);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL lock_frame2_rdy got %b exp 1", rdy); end
    checks++; if (state !== 3'd5) begin errors++; $display("FAIL lock_run_state got %0d exp 5", state); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL lock_err_cnt got %0d exp 0", err_cnt); end
    frame_end();
    $display("test_lock done");
  endtask

  task automatic test_timeout();
    en = 1'b0;
    tick();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL to_idle_state got %0d exp 0", state); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL to_idle_rdy got %b exp 0", rdy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_idle_err got %b exp 0", err); end
    train_done = 2'b01;
    en = 1'b1;
    tick();
    tick();
    repeat (31) tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_early_err got %b exp 0", err); end
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL to_early_state got %0d exp 2", state); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", err); end
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL to_state got %0d exp 1", state); end
    checks++; if (train_start !== 2'b11) begin errors++; $display("FAIL to_train_start got %b exp 11", train_start); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL to_err_cnt got %0d exp 1", err_cnt); end
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_pulse got %b exp 0", err); end
    train_done = 2'b11;
    tick();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL to_release got %0d exp 3", state); end
    frame_rise(1);
    frame_end();
    frame_rise(1);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL to_relock_rdy got %b exp 1", rdy); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL to_relock_err_cnt got %0d exp 1", err_cnt); end
    frame_end();
    $display("test_timeout done");
  endtask

  task automatic test_skew();
    en = 1'b0;
    tick();
    en = 1'b1;
    repeat (3) tick();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL skew_release got %0d exp 3", state); end
    frame_valid = 2'b01;
    tick();
    repeat (4) tick();
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL skew_align_state got %0d exp 4", state); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL skew_early_err got %b exp 0", err); end
    frame_valid = 2'b11;
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL skew_err got %b exp 1", err); end
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL skew_state got %0d exp 1", state); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL skew_rdy got %b exp 0", rdy); end
    checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL skew_err_cnt got %0d exp 2", err_cnt); end
    frame_end();
    frame_rise(0);
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL skew0_frame1_state got %0d exp 3", state); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL skew0_frame1_rdy got %b exp 0", rdy); end
    frame_end();
    frame_rise(0);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL skew0_rdy got %b exp 1", rdy); end
    checks++; if (state !== 3'd5) begin errors++; $display("FAIL skew0_state got %0d exp 5", state); end
    frame_end();
    $display("test_skew done");
  endtask

  task automatic test_lock_loss();
    train_done = 2'b10;
    tick();
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL loss_rdy got %b exp 0", rdy); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL loss_err got %b exp 1", err); end
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL loss_state got %0d exp 1", state); end
    checks++; if (train_start !== 2'b11) begin errors++; $display("FAIL loss_train_start got %b exp 11", train_start); end
    checks++; if (err_cnt !== 8'd3) begin errors++; $display("FAIL loss_err_cnt got %0d exp 3", err_cnt); end
    train_done = 2'b11;
    repeat (2) tick();
    frame_rise(4);
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL loss_skewmax_frame1 got %0d exp 3", state); end
    frame_end();
    frame_rise(4);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL loss_relock_rdy got %b exp 1", rdy); end
    checks++; if (state !== 3'd5) begin errors++; $display("FAIL loss_relock_state got %0d exp 5", state); end
    frame_end();
    $display("test_lock_loss done");
  endtask

  task automatic test_run_align();
    frame_rise(2);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL run_ok_rdy got %b exp 1", rdy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL run_ok_err got %b exp 0", err); end
    frame_end();
    frame_valid = 2'b01;
    tick();
    repeat (4) tick();
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL run_track_rdy got %b exp 1", rdy); end
    frame_valid = 2'b11;
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL run_mis_err got %b exp 1", err); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL run_mis_rdy got %b exp 0", rdy); end
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL run_mis_state got %0d exp 1", state); end
    checks++; if (err_cnt !== 8'd4) begin errors++; $display("FAIL run_mis_err_cnt got %0d exp 4", err_cnt); end
    frame_end();
    $display("test_run_align done");
  endtask

  task automatic test_saturate();
    bit seen_err;
    en = 1'b0;
    train_done = 2'b00;
    tick();
    en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      seen_err = 1'b0;
      for (int k = 0; k < 40 && !seen_err; k++) begin
        tick();
        if (err === 1'b1) seen_err = 1'b1;
      end
      if (!seen_err) begin
        checks++; errors++;
        $display("FAIL sat_timeout_wait got no err within 40 cycles exp err at timeout %0d", i);
        break;
      end
      if (i == 99) begin
        checks++; if (err_cnt !== 8'd104) begin errors++; $display("FAIL sat_mid_err_cnt got %0d exp 104", err_cnt); end
      end
    end
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_err_cnt got %0d exp 255", err_cnt); end
    $display("test_saturate done");
  endtask

  task automatic test_en_align();
    train_done = 2'b11;
    repeat (2) tick();
    frame_valid = 2'b01;
    tick();
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL en_align_state got %0d exp 4", state); end
    en = 1'b0;
    tick();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL en_idle_state got %0d exp 0", state); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL en_idle_err got %b exp 0", err); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL en_idle_rdy got %b exp 0", rdy); end
    checks++; if (sensor_train !== 1'b1) begin errors++; $display("FAIL en_idle_sensor_train got %b exp 1", sensor_train); end
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL en_idle_err_cnt got %0d exp 255", err_cnt); end
    frame_valid = 2'b00;
    tick();
    $display("test_en_align done");
  endtask

  task automatic test_reset_run();
    en = 1'b1;
    repeat (3) tick();
    frame_rise(0);
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL rr_frame1_state got %0d exp 3", state); end
    frame_end();
    frame_rise(0);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rr_run_rdy got %b exp 1", rdy); end
    rst_px = 1'b1;
    #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rr_async_state got %0d exp 0", state); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rr_async_rdy got %b exp 0", rdy); end
    checks++; if (sensor_train !== 1'b1) begin errors++; $display("FAIL rr_async_sensor_train got %b exp 1", sensor_train); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rr_async_err_cnt got %0d exp 0", err_cnt); end
    checks++; if (train_start !== 2'b00) begin errors++; $display("FAIL rr_async_train_start got %b exp 00", train_start); end
    tick();
    rst_px = 1'b0;
    tick();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL rr_restart_state got %0d exp 1", state); end
    checks++; if (train_start !== 2'b11) begin errors++; $display("FAIL rr_restart_train_start got %b exp 11", train_start); end
    $display("test_reset_run done");
  endtask

  initial begin
    test_reset();
    test_lock();
    test_timeout();
    test_skew();
    test_lock_loss();
    test_run_align();
    test_saturate();
    test_en_align();
    test_reset_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
